alu_op_issue: RTL and testbench

Sequential issue/retire stage wrapped around the combinational 5-bit ALU (5-bit a/b, 4-bit control, 10-bit out). Accepts operation requests over a valid/ready handshake and buffers them in a small FIFO. Presents the FIFO head to the ALU, then captures the ALU result into a registered, tagged output stage with its own valid/ready. Substitutes a defined result for divide-by-zero and counts those events.

---
 rtl/alu_op_issue_if.sv | 26 ++
 rtl/alu_op_issue.sv | 118 +++++++++++
 tb/tb_alu_op_issue.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_issue_if.sv
// Request and result channels of the ALU issue stage.
// master = requester/consumer side, slave = the issue stage.
interface alu_op_issue_if #(
  parameter int TAG_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_a;
  logic [4:0]       in_b;
  logic [3:0]       in_control;
  logic             res_valid;
  logic             res_ready;
  logic [9:0]       res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_dz;

  modport master (
    output in_valid, in_a, in_b, in_control, res_ready,
    input  in_ready, res_valid, res_data, res_tag, res_dz
  );

  modport slave (
    input  in_valid, in_a, in_b, in_control, res_ready,
    output in_ready, res_valid, res_data, res_tag, res_dz
  );
endinterface

// File: rtl/alu_op_issue.sv
// Issue/retire stage around a combinational 5-bit ALU: requests are queued
// in a small FIFO, the head drives the ALU, and the ALU result is captured
// into a tagged result register. Divide-by-zero gets a fixed substitute.
module alu_op_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3,
  parameter int DZC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_issue_if.slave    bus,
  output logic [4:0]       alu_a,
  output logic [4:0]       alu_b,
  output logic [3:0]       alu_control,
  input  logic [9:0]       alu_out,
  output logic [DZC_W-1:0] dz_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [TAG_W-1:0] TAG_ONE = {{(TAG_W-1){1'b0}}, 1'b1};
  localparam logic [DZC_W-1:0] DZC_ONE = {{(DZC_W-1){1'b0}}, 1'b1};

  function automatic logic [DZC_W-1:0] sat_inc(input logic [DZC_W-1:0] v);
    return (&v) ? v : v + DZC_ONE;
  endfunction

  function automatic logic is_div_zero(input logic [3:0] c, input logic [4:0] b);
    return (c[3:2] == 2'b11) && (b == 5'd0);
  endfunction

  // Request storage; the extra pointer bit separates full from empty.
  logic [4:0]       mem_a [DEPTH];
  logic [4:0]       mem_b [DEPTH];
  logic [3:0]       mem_c [DEPTH];
  logic [TAG_W-1:0] mem_t [DEPTH];

  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [TAG_W-1:0] tag_cnt;
  logic             full, empty, push, issue;
  logic [PTR_W-1:0] wr_idx, rd_idx;

  // Result register (stage p1).
  logic             vld_p1;
  logic [9:0]       data_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             dz_p1;
  logic [DZC_W-1:0] dz_cnt;

  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
  assign push   = bus.in_valid && !full;
  assign issue  = !empty && (!vld_p1 || bus.res_ready);

  assign bus.in_ready  = !full;
  assign bus.res_valid = vld_p1;
  assign bus.res_data  = data_p1;
  assign bus.res_tag   = tag_p1;
  assign bus.res_dz    = dz_p1;
  assign dz_count      = dz_cnt;

  // FIFO storage write; contents need no reset since pointers gate them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_idx] <= bus.in_a;
      mem_b[wr_idx] <= bus.in_b;
      mem_c[wr_idx] <= bus.in_control;
      mem_t[wr_idx] <= tag_cnt;
    end
  end

  // Head entry drives the ALU directly from storage; zero when empty.
  always_comb begin
    alu_a       = 5'd0;
    alu_b       = 5'd0;
    alu_control = 4'd0;
    if (!empty) begin
      alu_a       = mem_a[rd_idx];
      alu_b       = mem_b[rd_idx];
      alu_control = mem_c[rd_idx];
    end
  end

  // Pointers, tag counter and result register (stage p0 -> p1).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      tag_p1  <= '0;
      dz_p1   <= 1'b0;
      dz_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        tag_cnt <= tag_cnt + TAG_ONE;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        vld_p1 <= 1'b1;
        tag_p1 <= mem_t[rd_idx];
        if (is_div_zero(alu_control, alu_b)) begin
          data_p1 <= 10'h3FF;
          dz_p1   <= 1'b1;
          dz_cnt  <= sat_inc(dz_cnt);
        end else begin
          data_p1 <= alu_out;
          dz_p1   <= 1'b0;
        end
      end else if (vld_p1 && bus.res_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: behavioural ALU, queue-based reference model,
// directed scenarios followed by random traffic.
module tb_alu_op_issue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 3;
  localparam int DZC_W = 8;
  localparam int DZ_MAX = (1 << DZC_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_issue_if #(.TAG_W(TAG_W)) bus();

  logic [4:0]       alu_a, alu_b;
  logic [3:0]       alu_control;
  logic [9:0]       alu_out;
  logic [DZC_W-1:0] dz_count;

  alu_op_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DZC_W(DZC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_out(alu_out), .dz_count(dz_count)
  );

  // Behavioural ALU
  function automatic logic [9:0] alu_fn(input logic [4:0] a, input logic [4:0] b,
                                        input logic [3:0] c);
    logic [9:0] ea, eb;
    ea = {5'd0, a};
    eb = {5'd0, b};
    case (c)
      4'b0000: return ea + eb;
      4'b0001: return ea - eb;
      4'b0100: return ea & eb;
      4'b0101: return ea | eb;
      4'b1000: return ea * eb;
      4'b1100: return (b == 0) ? 10'd0 : ea / eb;
      4'b1101: return (b == 0) ? 10'd0 : ea % eb;
      default: return ea ^ eb;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_control);

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]       a;
    logic [4:0]       b;
    logic [3:0]       c;
    logic [TAG_W-1:0] t;
    logic [9:0]       d;
    logic             dz;
  } ent_t;

  ent_t             pend[$];
  ent_t             held;
  logic             held_v;
  logic [TAG_W-1:0] mtag;
  int               mdz;
  int               dut_acc = 0;

  // One clock of stimulus with model update and checks.
  task automatic step(input logic v, input logic [4:0] a, input logic [4:0] b,
                      input logic [3:0] c, input logic rr, input logic r = 1'b0);
    logic do_push, do_pop;
    ent_t e;
    bus.in_valid   = v;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_control = c;
    bus.res_ready  = rr;
    rst            = r;
    if (!r) begin
      chk("in_ready", bus.in_ready, pend.size() < DEPTH);
      if (pend.size() > 0) begin
        chk("alu_a", alu_a, pend[0].a);
        chk("alu_b", alu_b, pend[0].b);
        chk("alu_control", alu_control, pend[0].c);
      end else begin
        chk("alu_idle", {alu_a, alu_b, alu_control}, 0);
      end
      if (v && bus.in_ready) dut_acc++;
    end
    do_push = v && (pend.size() < DEPTH);
    do_pop  = (pend.size() > 0) && (!held_v || rr);
    @(posedge clk);
    if (r) begin
      pend.delete();
      held_v = 1'b0;
      held   = '{a: 0, b: 0, c: 0, t: 0, d: 0, dz: 0};
      mtag   = '0;
      mdz    = 0;
    end else begin
      if (do_pop) begin
        held   = pend.pop_front();
        held_v = 1'b1;
        if (held.dz && mdz < DZ_MAX) mdz++;
      end else if (held_v && rr) begin
        held_v = 1'b0;
      end
      if (do_push) begin
        e.a  = a;
        e.b  = b;
        e.c  = c;
        e.t  = mtag;
        e.dz = (c[3:2] == 2'b11) && (b == 0);
        e.d  = e.dz ? 10'h3FF : alu_fn(a, b, c);
        pend.push_back(e);
        mtag = mtag + 1'b1;
      end
    end
    #1;
    chk("res_valid", bus.res_valid, held_v);
    chk("res_data", bus.res_data, held.d);
    chk("res_tag", bus.res_tag, held.t);
    chk("res_dz", bus.res_dz, held.dz);
    chk("dz_count", dz_count, mdz);
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 5'd0, 5'd0, 4'd0, rr);
  endtask

  task automatic do_reset();
    step(1'b0, 5'd0, 5'd0, 4'd0, 1'b0, 1'b1);
  endtask

  logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101,
                          4'b1000, 4'b1100, 4'b1101, 4'b1111};

  initial begin
    int acc0;
    logic [4:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_control = '0;
    rst = 1'b1;

    // Reset state
    do_reset();
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_tag", bus.res_tag, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_dz_count", dz_count, 0);

    // Multiply 7*3
    step(1'b1, 5'd7, 5'd3, 4'b1000, 1'b1);
    idle(1'b1);
    chk("mul_valid", bus.res_valid, 1);
    chk("mul_data", bus.res_data, 21);
    chk("mul_tag", bus.res_tag, 0);
    chk("mul_dz", bus.res_dz, 0);
    idle(1'b1);
    chk("mul_drop", bus.res_valid, 0);

    // Divide by zero, then a normal divide
    step(1'b1, 5'd9, 5'd0, 4'b1100, 1'b1);
    idle(1'b1);
    chk("dz_data", bus.res_data, 10'h3FF);
    chk("dz_flag", bus.res_dz, 1);
    chk("dz_cnt1", dz_count, 1);
    step(1'b1, 5'd9, 5'd2, 4'b1100, 1'b1);
    idle(1'b1);
    chk("div_data", bus.res_data, 4);
    chk("div_flag", bus.res_dz, 0);
    chk("div_cnt", dz_count, 1);

    // Full backpressure: DEPTH queued + 1 held
    do_reset();
    acc0 = dut_acc;
    for (int i = 0; i < 8; i++)
      step(1'b1, 5'(i + 2), 5'd3, 4'b0000, 1'b0);
    chk("bp_accepted", dut_acc - acc0, DEPTH + 1);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_held_data", bus.res_data, 5);
    chk("bp_held_tag", bus.res_tag, 0);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b1);
      chk("bp_drain_tag", bus.res_tag, i);
      chk("bp_drain_valid", bus.res_valid, 1);
    end
    chk("bp_in_ready_back", bus.in_ready, 1);
    idle(1'b1);

    // Streaming adds with tag wrap
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'(i), 5'd1, 4'b0000, 1'b1);
      if (i > 0) begin
        chk("stream_data", bus.res_data, i);
        chk("stream_tag", bus.res_tag, (i - 1) % 8);
      end
    end
    idle(1'b1);
    chk("stream_last_data", bus.res_data, 10);
    chk("stream_last_tag", bus.res_tag, 1);
    idle(1'b1);

    // Reset in the middle of a backpressured burst
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'(i), 5'd0, 4'b1100, 1'b0);
    do_reset();
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_dz", dz_count, 0);
    step(1'b1, 5'd5, 5'd6, 4'b0000, 1'b1);
    idle(1'b1);
    chk("mid_rst_tag", bus.res_tag, 0);
    chk("mid_rst_data", bus.res_data, 11);

    // Divide-by-zero counter saturation
    do_reset();
    for (int i = 0; i < 260; i++)
      step(1'b1, 5'($urandom_range(0, 31)), 5'd0, {2'b11, 2'($urandom_range(0, 3))}, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("dz_sat", dz_count, DZ_MAX);
    step(1'b1, 5'd1, 5'd0, 4'b1100, 1'b1);
    idle(1'b1);
    chk("dz_sat_hold", dz_count, DZ_MAX);

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ra = 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), ra, rb, ops[$urandom_range(0, 7)],
           1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
